// File: rtl/add_sub_pkg.sv
// Shared types for the add/sub counter family.
package add_sub_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } add_sub_mode_e;

endpackage : add_sub_pkg

// File: rtl/add_sub_counter_bounded_if.sv
// Control/status bundle of the bounded add/sub counter; clock and reset stay outside.
interface add_sub_counter_bounded_if
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic              en_i;
  logic              addsub_i;
  logic [WIDTH-1:0]  step_i;
  add_sub_mode_e     mode_i;
  logic              load_i;
  logic [WIDTH-1:0]  load_val_i;
  logic              clr_flags_i;
  logic [WIDTH-1:0]  out_o;
  logic              ovf_o;
  logic              unf_o;
  logic              wrap_o;
  logic              at_max_o;
  logic              at_min_o;

  modport master (
    output en_i, addsub_i, step_i, mode_i, load_i, load_val_i, clr_flags_i,
    input  out_o, ovf_o, unf_o, wrap_o, at_max_o, at_min_o
  );

  modport slave (
    input  en_i, addsub_i, step_i, mode_i, load_i, load_val_i, clr_flags_i,
    output out_o, ovf_o, unf_o, wrap_o, at_max_o, at_min_o
  );

endinterface : add_sub_counter_bounded_if

// File: rtl/add_sub_step_unit.sv
// Combinational step: applies a clamped step in WIDTH+2-bit signed arithmetic and
// folds a bound crossing back into [MIN_VAL..MAX_VAL] by wrapping or saturating.
module add_sub_step_unit
  import add_sub_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic             dir_i,
  input  add_sub_mode_e    mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             ovf_o,
  output logic             unf_o
);
  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] MIN_E   = EW'(MIN_VAL);
  localparam logic signed [EW-1:0] MAX_E   = EW'(MAX_VAL);
  localparam logic signed [EW-1:0] RANGE_E = EW'(MAX_VAL - MIN_VAL + 1);

  logic signed [EW-1:0] w_val;
  logic signed [EW-1:0] w_step_raw;
  logic signed [EW-1:0] w_step;
  logic signed [EW-1:0] w_sum;
  logic signed [EW-1:0] w_diff;
  logic signed [EW-1:0] w_res;

  assign w_val      = $signed({2'b00, value_i});
  assign w_step_raw = $signed({2'b00, step_i});
  // A step larger than the range would wrap more than once; cap it at one full lap.
  assign w_step     = (w_step_raw > RANGE_E) ? RANGE_E : w_step_raw;
  assign w_sum      = w_val + w_step;
  assign w_diff     = w_val - w_step;

  // Select the folded result and raise the crossing strobes.
  always_comb begin
    w_res = w_val;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    if (dir_i == 1'b0) begin
      if (w_sum > MAX_E) begin
        ovf_o = 1'b1;
        if (mode_i == MODE_SAT) begin
          w_res = MAX_E;
        end else begin
          w_res = w_sum - RANGE_E;
        end
      end else begin
        w_res = w_sum;
      end
    end else begin
      if (w_diff < MIN_E) begin
        unf_o = 1'b1;
        if (mode_i == MODE_SAT) begin
          w_res = MIN_E;
        end else begin
          w_res = w_diff + RANGE_E;
        end
      end else begin
        w_res = w_diff;
      end
    end
  end

  assign next_o = WIDTH'(w_res);

endmodule : add_sub_step_unit

// File: rtl/add_sub_counter_bounded.sv
// Bounded up/down counter: count register, load clamp, sticky over/underflow
// flags and a one-cycle wrap/saturate pulse around add_sub_step_unit.
module add_sub_counter_bounded
  import add_sub_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int RESET_VAL = MIN_VAL
) (
  input logic                      clk_i,
  input logic                      reset_i,
  add_sub_counter_bounded_if.slave bus
);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  if ((WIDTH < 2) || (MIN_VAL < 0) || (MIN_VAL >= MAX_VAL) || (MAX_VAL >= (1 << WIDTH)) ||
      (RESET_VAL < MIN_VAL) || (RESET_VAL > MAX_VAL)) begin : g_bad_params
    $error("add_sub_counter_bounded: illegal WIDTH/MIN_VAL/MAX_VAL/RESET_VAL combination");
  end

  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_unf;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_out_next;
  logic             w_cross_ovf;
  logic             w_cross_unf;
  logic             w_ovf_set;
  logic             w_unf_set;

  add_sub_step_unit #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .value_i (r_out),
    .step_i  (bus.step_i),
    .dir_i   (bus.addsub_i),
    .mode_i  (bus.mode_i),
    .next_o  (w_count_next),
    .ovf_o   (w_cross_ovf),
    .unf_o   (w_cross_unf)
  );

  // Clamp the load value into the legal window.
  always_comb begin
    if (bus.load_val_i < MIN_W) begin
      w_load_clamped = MIN_W;
    end else if (bus.load_val_i > MAX_W) begin
      w_load_clamped = MAX_W;
    end else begin
      w_load_clamped = bus.load_val_i;
    end
  end

  // Load beats count; crossings only count when the step is actually applied.
  always_comb begin
    w_out_next = r_out;
    w_ovf_set  = 1'b0;
    w_unf_set  = 1'b0;
    if (bus.load_i) begin
      w_out_next = w_load_clamped;
    end else if (bus.en_i) begin
      w_out_next = w_count_next;
      w_ovf_set  = w_cross_ovf;
      w_unf_set  = w_cross_unf;
    end else begin
      w_out_next = r_out;
    end
  end

  // State registers; a new crossing outranks a same-cycle flag clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_out  <= RESET_W;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_out_next;
      r_ovf  <= w_ovf_set | (r_ovf & ~bus.clr_flags_i);
      r_unf  <= w_unf_set | (r_unf & ~bus.clr_flags_i);
      r_wrap <= w_ovf_set | w_unf_set;
    end
  end

  assign bus.out_o    = r_out;
  assign bus.ovf_o    = r_ovf;
  assign bus.unf_o    = r_unf;
  assign bus.wrap_o   = r_wrap;
  assign bus.at_max_o = (r_out == MAX_W);
  assign bus.at_min_o = (r_out == MIN_W);

endmodule : add_sub_counter_bounded

// File: tb/tb_add_sub_counter_bounded.sv
// Scoreboard bench: a bounded instance (2..12) and a default-parameter instance (0..15).
module tb_add_sub_counter_bounded;
  import add_sub_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  add_sub_counter_bounded_if #(.WIDTH(4)) if0 ();
  add_sub_counter_bounded_if #(.WIDTH(4)) if1 ();

  add_sub_counter_bounded #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .RESET_VAL(2)) dut0 (
    .clk_i(clk), .reset_i(reset), .bus(if0.slave));
  add_sub_counter_bounded #(.WIDTH(4)) dut1 (
    .clk_i(clk), .reset_i(reset), .bus(if1.slave));

  typedef struct {
    logic [3:0] out;
    logic       ovf;
    logic       unf;
    logic       wrap;
  } exp_t;

  exp_t  q0[$];
  exp_t  q1[$];
  string t0[$];
  string t1[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  event  chk_ev;

  task automatic drv(input int id, input logic en, input logic sub, input logic [3:0] step,
                     input add_sub_mode_e mode, input logic load, input logic [3:0] lval,
                     input logic clr);
    if (id == 0) begin
      if0.en_i = en; if0.addsub_i = sub; if0.step_i = step; if0.mode_i = mode;
      if0.load_i = load; if0.load_val_i = lval; if0.clr_flags_i = clr;
    end else begin
      if1.en_i = en; if1.addsub_i = sub; if1.step_i = step; if1.mode_i = mode;
      if1.load_i = load; if1.load_val_i = lval; if1.clr_flags_i = clr;
    end
  endtask

  task automatic push(input int id, input logic [3:0] out, input logic ovf, input logic unf,
                      input logic wrap, input string tag);
    exp_t e;
    e.out = out; e.ovf = ovf; e.unf = unf; e.wrap = wrap;
    if (id == 0) begin
      q0.push_back(e); t0.push_back(tag);
    end else begin
      q1.push_back(e); t1.push_back(tag);
    end
  endtask

  // One clock edge with the current inputs, then record what should follow it.
  task automatic cyc(input int id, input logic [3:0] out, input logic ovf, input logic unf,
                     input logic wrap, input string tag);
    @(posedge clk);
    push(id, out, ovf, unf, wrap, tag);
    #1;
  endtask

  task automatic compare(input int id, input exp_t e, input string tag);
    logic [3:0] o;
    logic f_o, f_u, w, mx, mn, emx, emn;
    if (id == 0) begin
      o = if0.out_o; f_o = if0.ovf_o; f_u = if0.unf_o; w = if0.wrap_o;
      mx = if0.at_max_o; mn = if0.at_min_o;
      emx = (e.out == 4'd12); emn = (e.out == 4'd2);
    end else begin
      o = if1.out_o; f_o = if1.ovf_o; f_u = if1.unf_o; w = if1.wrap_o;
      mx = if1.at_max_o; mn = if1.at_min_o;
      emx = (e.out == 4'd15); emn = (e.out == 4'd0);
    end
    n_chk++;
    if ({o, f_o, f_u, w, mx, mn} !== {e.out, e.ovf, e.unf, e.wrap, emx, emn}) begin
      n_fail++;
      $display("FAIL %s: got out=%0d ovf=%b unf=%b wrap=%b at_max=%b at_min=%b, expected out=%0d ovf=%b unf=%b wrap=%b at_max=%b at_min=%b",
               tag, o, f_o, f_u, w, mx, mn, e.out, e.ovf, e.unf, e.wrap, emx, emn);
    end
  endtask

  // Monitor: pops one expectation per instance at each falling edge or on demand.
  always begin
    @(negedge clk or chk_ev);
    if (q0.size() != 0) compare(0, q0.pop_front(), t0.pop_front());
    if (q1.size() != 0) compare(1, q1.pop_front(), t1.pop_front());
  end

  initial begin
    drv(0, 1'b0, 1'b0, 4'd0, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    drv(1, 1'b0, 1'b0, 4'd0, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    push(0, 4'd2, 1'b0, 1'b0, 1'b0, "reset0");
    push(1, 4'd0, 1'b0, 1'b0, 1'b0, "reset1");
    reset = 1'b0;

    // Wrap mode, add 3 from 2
    drv(0, 1'b1, 1'b0, 4'd3, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd5,  1'b0, 1'b0, 1'b0, "add3_a");
    cyc(0, 4'd8,  1'b0, 1'b0, 1'b0, "add3_b");
    cyc(0, 4'd11, 1'b0, 1'b0, 1'b0, "add3_c");
    cyc(0, 4'd3,  1'b1, 1'b0, 1'b1, "add3_wrap");
    drv(0, 1'b0, 1'b0, 4'd3, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd3,  1'b1, 1'b0, 1'b0, "hold_after_wrap");
    drv(0, 1'b0, 1'b0, 4'd3, MODE_WRAP, 1'b0, 4'd0, 1'b1);
    cyc(0, 4'd3,  1'b0, 1'b0, 1'b0, "clr_alone");
    drv(0, 1'b1, 1'b0, 4'd3, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd6,  1'b0, 1'b0, 1'b0, "add3_d");
    cyc(0, 4'd9,  1'b0, 1'b0, 1'b0, "add3_e");
    cyc(0, 4'd12, 1'b0, 1'b0, 1'b0, "sum_eq_max");
    cyc(0, 4'd4,  1'b1, 1'b0, 1'b1, "wrap_ovf2");
    drv(0, 1'b1, 1'b0, 4'd15, MODE_WRAP, 1'b0, 4'd0, 1'b1);
    cyc(0, 4'd4,  1'b1, 1'b0, 1'b1, "clr_vs_set_clamped_step");
    drv(0, 1'b0, 1'b0, 4'd0, MODE_WRAP, 1'b0, 4'd0, 1'b1);
    cyc(0, 4'd4,  1'b0, 1'b0, 1'b0, "clr2");
    drv(0, 1'b1, 1'b0, 4'd0, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd4,  1'b0, 1'b0, 1'b0, "step0");

    // Saturate mode
    drv(0, 1'b1, 1'b1, 4'd4, MODE_SAT, 1'b1, 4'd10, 1'b0);
    cyc(0, 4'd10, 1'b0, 1'b0, 1'b0, "load10");
    drv(0, 1'b1, 1'b1, 4'd4, MODE_SAT, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd6,  1'b0, 1'b0, 1'b0, "sub4_a");
    cyc(0, 4'd2,  1'b0, 1'b0, 1'b0, "sub_to_min");
    cyc(0, 4'd2,  1'b0, 1'b1, 1'b1, "sat_unf");
    drv(0, 1'b1, 1'b1, 4'd1, MODE_SAT, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd2,  1'b0, 1'b1, 1'b1, "sat_unf_again");
    drv(0, 1'b0, 1'b1, 4'd1, MODE_SAT, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd2,  1'b0, 1'b1, 1'b0, "sat_hold");
    drv(0, 1'b1, 1'b0, 4'd15, MODE_SAT, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd12, 1'b1, 1'b1, 1'b1, "sat_ovf_clamped_step");
    drv(0, 1'b1, 1'b0, 4'd1, MODE_SAT, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd12, 1'b1, 1'b1, 1'b1, "sat_stay_max");
    drv(0, 1'b1, 1'b0, 4'd1, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd2,  1'b1, 1'b1, 1'b1, "wrap_from_max");
    drv(0, 1'b1, 1'b1, 4'd1, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd12, 1'b1, 1'b1, 1'b1, "wrap_from_min");

    // Load clamp, load beats count
    drv(0, 1'b1, 1'b0, 4'd3, MODE_WRAP, 1'b1, 4'd14, 1'b0);
    cyc(0, 4'd12, 1'b1, 1'b1, 1'b0, "load_clamp_hi");
    drv(0, 1'b1, 1'b0, 4'd3, MODE_WRAP, 1'b1, 4'd0, 1'b0);
    cyc(0, 4'd2,  1'b1, 1'b1, 1'b0, "load_clamp_lo");
    drv(0, 1'b1, 1'b0, 4'd3, MODE_WRAP, 1'b1, 4'd7, 1'b0);
    cyc(0, 4'd7,  1'b1, 1'b1, 1'b0, "load7");
    drv(0, 1'b1, 1'b0, 4'd3, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd10, 1'b1, 1'b1, 1'b0, "pre_reset");

    // Asynchronous reset between edges
    @(negedge clk);
    #1;
    reset = 1'b1;
    drv(0, 1'b0, 1'b0, 4'd3, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    #1;
    push(0, 4'd2, 1'b0, 1'b0, 1'b0, "async_reset");
    ->chk_ev;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drv(0, 1'b1, 1'b0, 4'd3, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(0, 4'd5,  1'b0, 1'b0, 1'b0, "after_reset");
    drv(0, 1'b0, 1'b0, 4'd3, MODE_WRAP, 1'b0, 4'd0, 1'b0);

    // Default-parameter instance: plain 4-bit modulo behaviour
    drv(1, 1'b1, 1'b0, 4'd0, MODE_WRAP, 1'b1, 4'd15, 1'b0);
    cyc(1, 4'd15, 1'b0, 1'b0, 1'b0, "d_load15");
    drv(1, 1'b1, 1'b0, 4'd1, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(1, 4'd0,  1'b1, 1'b0, 1'b1, "d_wrap_up");
    drv(1, 1'b1, 1'b1, 4'd1, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(1, 4'd15, 1'b1, 1'b1, 1'b1, "d_wrap_down");
    drv(1, 1'b0, 1'b1, 4'd1, MODE_WRAP, 1'b0, 4'd0, 1'b0);
    cyc(1, 4'd15, 1'b1, 1'b1, 1'b0, "d_hold");

    for (int i = 0; i < 5 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_add_sub_counter_bounded
